// File: rtl/event_wait_sched_if.sv
// Handshake bundle between event producers / waiter and event_wait_sched.
//   master : producer/waiter side  -> drives evt_req, arm
//   slave  : scheduler side        -> drives evt_fire, evt_id, evt_onehot,
//                                     pending, armed (+ coalesce_cnt)
// Optional macro: EVENT_WAIT_SCHED_COALESCE_CNT_EN adds coalesce_cnt.
interface event_wait_sched_if #(
  parameter int N_EVENTS = 3,
  parameter int CNT_W    = 8
);
  localparam int ID_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

  if (N_EVENTS < 2 || N_EVENTS > 16 || CNT_W < 1) begin : g_bad_param
    $error("event_wait_sched_if: N_EVENTS must be 2..16 and CNT_W >= 1");
  end

  logic [N_EVENTS-1:0] evt_req;
  logic                arm;
  logic                evt_fire;
  logic [ID_W-1:0]     evt_id;
  logic [N_EVENTS-1:0] evt_onehot;
  logic [N_EVENTS-1:0] pending;
  logic                armed;
`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
  logic [CNT_W-1:0]    coalesce_cnt;

  modport master (
    output evt_req, arm,
    input  evt_fire, evt_id, evt_onehot, pending, armed, coalesce_cnt
  );
  modport slave (
    input  evt_req, arm,
    output evt_fire, evt_id, evt_onehot, pending, armed, coalesce_cnt
  );
`else
  modport master (
    output evt_req, arm,
    input  evt_fire, evt_id, evt_onehot, pending, armed
  );
  modport slave (
    input  evt_req, arm,
    output evt_fire, evt_id, evt_onehot, pending, armed
  );
`endif
endinterface

// File: rtl/event_wait_sched.sv
// Event wait scheduler: latches one-cycle event pulses as pending and wakes a
// single waiter with exactly one event per arm, chosen round-robin.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - event_wait_sched_if.slave (evt_req/arm in; evt_fire, evt_id,
//          evt_onehot, pending, armed [, coalesce_cnt] out, all registered)
// Optional macro: EVENT_WAIT_SCHED_COALESCE_CNT_EN enables the saturating
// retrigger-while-pending counter on bus.coalesce_cnt.
module event_wait_sched #(
  parameter int N_EVENTS = 3,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  event_wait_sched_if.slave  bus
);
  localparam int ID_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;
  localparam logic [N_EVENTS-1:0] ONE = {{(N_EVENTS-1){1'b0}}, 1'b1};

  if (N_EVENTS < 2 || N_EVENTS > 16 || CNT_W < 1) begin : g_bad_param
    $error("event_wait_sched: N_EVENTS must be 2..16 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FIRE
  } state_t;

  state_t              r_state;
  logic [N_EVENTS-1:0] r_pending;
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_fire;
  logic [ID_W-1:0]     r_id;
  logic [N_EVENTS-1:0] r_onehot;
  logic                r_armed;

  logic                w_sel_found;
  logic [ID_W-1:0]     w_sel_idx;
  logic [ID_W-1:0]     w_rr_next;
  logic                w_take;
  logic [N_EVENTS-1:0] w_grant;
  int unsigned         w_scan;

  // Round-robin pick: first pending bit at or above r_rr_ptr, wrapping.
  // Grant decisions use the registered pending mask, so a request seen at
  // edge k is eligible at edge k+1 at the earliest.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_scan      = 0;
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      w_scan = 32'(r_rr_ptr) + i;
      if (w_scan >= N_EVENTS) w_scan = w_scan - N_EVENTS;
      if (!w_sel_found && (|(r_pending & (ONE << w_scan)))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = ID_W'(w_scan);
      end
    end
  end

  always_comb begin
    w_rr_next = (w_sel_idx == ID_W'(N_EVENTS - 1)) ? '0 : w_sel_idx + 1'b1;
    // A FIRE cycle with a fresh arm may grant again immediately, giving
    // back-to-back wakes; otherwise a grant needs the ARMED state.
    w_take    = w_sel_found &&
                ((r_state == S_ARMED) || ((r_state == S_FIRE) && bus.arm));
    w_grant   = w_take ? (ONE << w_sel_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_fire    <= 1'b0;
      r_id      <= '0;
      r_onehot  <= '0;
      r_armed   <= 1'b0;
    end else begin
      // A request on the bit being granted re-sets it as a new occurrence.
      r_pending <= (r_pending & ~w_grant) | bus.evt_req;
      r_fire    <= w_take;
      r_onehot  <= w_grant;
      if (w_take) begin
        r_id     <= w_sel_idx;
        r_rr_ptr <= w_rr_next;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end
        end
        S_ARMED: begin
          // Arms arriving here are dropped: one wake per arm, no queuing.
          if (w_take) begin
            r_state <= S_FIRE;
            r_armed <= 1'b0;
          end
        end
        S_FIRE: begin
          if (w_take) begin
            r_state <= S_FIRE;
            r_armed <= 1'b0;
          end else if (bus.arm) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.evt_fire   = r_fire;
  assign bus.evt_id     = r_id;
  assign bus.evt_onehot = r_onehot;
  assign bus.pending    = r_pending;
  assign bus.armed      = r_armed;

`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
  localparam int SUM_W = CNT_W + 5;

  logic [CNT_W-1:0] r_coalesce_cnt;
  logic [SUM_W-1:0] w_cnt_sum;

  // Headroom bits above CNT_W detect overflow for saturation.
  always_comb begin
    w_cnt_sum = {5'b0, r_coalesce_cnt} +
                SUM_W'($countones(bus.evt_req & r_pending & ~w_grant));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coalesce_cnt <= '0;
    end else if (|w_cnt_sum[SUM_W-1:CNT_W]) begin
      r_coalesce_cnt <= '1;
    end else begin
      r_coalesce_cnt <= w_cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.coalesce_cnt = r_coalesce_cnt;
`endif

endmodule

// File: tb/tb_event_wait_sched.sv
module tb_event_wait_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  event_wait_sched_if #(.N_EVENTS(3), .CNT_W(2)) bus ();

  event_wait_sched #(.N_EVENTS(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       arm;
    logic       fire;
    logic [1:0] id;
    logic [2:0] oh;
    logic [2:0] pend;
    logic       armed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [2:0] q, input logic a,
                             input logic f, input logic [1:0] id,
                             input logic [2:0] oh, input logic [2:0] p,
                             input logic ar);
    vec_t t;
    t.rst = r; t.req = q; t.arm = a;
    t.fire = f; t.id = id; t.oh = oh; t.pend = p; t.armed = ar;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] q, input logic a);
    rst         = r;
    bus.evt_req = q;
    bus.arm     = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fires;

  initial begin
    drive(1'b0, 3'b000, 1'b0);

    //          rst req    arm  fire id  onehot pend   armed
    vecs.push_back(v(1, 3'b111, 1,  0, 0, 3'b000, 3'b000, 0)); // reset wins
    vecs.push_back(v(0, 3'b000, 1,  0, 0, 3'b000, 3'b000, 1)); // T1 arm
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b000, 1));
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b000, 1));
    vecs.push_back(v(0, 3'b001, 0,  0, 0, 3'b000, 3'b001, 1)); // req
    vecs.push_back(v(0, 3'b000, 0,  1, 0, 3'b001, 3'b000, 0)); // fire
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b000, 0));
    vecs.push_back(v(1, 3'b000, 0,  0, 0, 3'b000, 3'b000, 0)); // T2
    vecs.push_back(v(0, 3'b111, 0,  0, 0, 3'b000, 3'b111, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b111, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b111, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 0, 3'b000, 3'b111, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 0, 3'b001, 3'b110, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 0, 3'b000, 3'b110, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 0, 3'b000, 3'b110, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 1, 3'b010, 3'b100, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 1, 3'b000, 3'b100, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 1, 3'b000, 3'b100, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 2, 3'b100, 3'b000, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 2, 3'b000, 3'b000, 0));
    vecs.push_back(v(0, 3'b001, 1,  0, 2, 3'b000, 3'b001, 1)); // T3 setup
    vecs.push_back(v(0, 3'b000, 0,  1, 0, 3'b001, 3'b000, 0)); // rr=1
    vecs.push_back(v(0, 3'b101, 0,  0, 0, 3'b000, 3'b101, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 0, 3'b000, 3'b101, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 2, 3'b100, 3'b001, 0)); // id2
    vecs.push_back(v(0, 3'b000, 1,  1, 0, 3'b001, 3'b000, 0)); // id0 b2b
    vecs.push_back(v(0, 3'b000, 1,  0, 0, 3'b000, 3'b000, 1)); // re-arm
    vecs.push_back(v(0, 3'b010, 0,  0, 0, 3'b000, 3'b010, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 1, 3'b010, 3'b000, 0)); // rr=2
    vecs.push_back(v(0, 3'b011, 0,  0, 1, 3'b000, 3'b011, 0)); // T4
    vecs.push_back(v(0, 3'b000, 1,  0, 1, 3'b000, 3'b011, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 0, 3'b001, 3'b010, 0)); // wrap
    vecs.push_back(v(0, 3'b000, 1,  1, 1, 3'b010, 3'b000, 0)); // b2b
    vecs.push_back(v(0, 3'b000, 0,  0, 1, 3'b000, 3'b000, 0));
    vecs.push_back(v(0, 3'b100, 1,  0, 1, 3'b000, 3'b100, 1));
    vecs.push_back(v(0, 3'b100, 0,  1, 2, 3'b100, 3'b100, 0)); // req on grant
    vecs.push_back(v(0, 3'b000, 0,  0, 2, 3'b000, 3'b100, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 2, 3'b000, 3'b100, 1));
    vecs.push_back(v(0, 3'b000, 0,  1, 2, 3'b100, 3'b000, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 2, 3'b000, 3'b000, 0));
    vecs.push_back(v(0, 3'b000, 1,  0, 2, 3'b000, 3'b000, 1)); // arm ignored
    vecs.push_back(v(0, 3'b000, 1,  0, 2, 3'b000, 3'b000, 1));
    vecs.push_back(v(0, 3'b010, 1,  0, 2, 3'b000, 3'b010, 1));
    vecs.push_back(v(0, 3'b000, 1,  1, 1, 3'b010, 3'b000, 0));
    vecs.push_back(v(0, 3'b000, 0,  0, 1, 3'b000, 3'b000, 0)); // no queued arm
    vecs.push_back(v(0, 3'b000, 0,  0, 1, 3'b000, 3'b000, 0));

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].arm);
      step();
      chk($sformatf("v%0d.fire", i),    32'(bus.evt_fire),   32'(vecs[i].fire));
      chk($sformatf("v%0d.id", i),      32'(bus.evt_id),     32'(vecs[i].id));
      chk($sformatf("v%0d.onehot", i),  32'(bus.evt_onehot), 32'(vecs[i].oh));
      chk($sformatf("v%0d.pending", i), 32'(bus.pending),    32'(vecs[i].pend));
      chk($sformatf("v%0d.armed", i),   32'(bus.armed),      32'(vecs[i].armed));
    end

    // T5: retrigger while pending coalesces to a single wake.
    drive(1, 3'b000, 0); step();
`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
    chk("t5.cnt_reset", 32'(bus.coalesce_cnt), 0);
`endif
    drive(0, 3'b001, 0); step();
    drive(0, 3'b001, 0); step();
    chk("t5.pending", 32'(bus.pending), 32'b001);
`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
    chk("t5.cnt_one", 32'(bus.coalesce_cnt), 1);
`endif
    drive(0, 3'b000, 1); step();
    chk("t5.armed", 32'(bus.armed), 1);
    drive(0, 3'b000, 0); step();
    chk("t5.fire", 32'(bus.evt_fire), 1);
    chk("t5.fire_id", 32'(bus.evt_id), 0);
    chk("t5.pend_clear", 32'(bus.pending), 0);
    drive(0, 3'b000, 1); step();
    drive(0, 3'b000, 0);
    fires = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.evt_fire) fires++;
    end
    chk("t5.no_second_fire", 32'(fires), 0);
    chk("t5.still_armed", 32'(bus.armed), 1);
    drive(1, 3'b000, 0); step();
    for (int k = 0; k < 6; k++) begin
      drive(0, 3'b001, 0); step();
    end
    chk("t5.sat_pending", 32'(bus.pending), 32'b001);
`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
    chk("t5.cnt_sat", 32'(bus.coalesce_cnt), 3);
`endif

    // T6: reset during a FIRE cycle discards everything.
    drive(1, 3'b000, 0); step();
    drive(0, 3'b111, 0); step();
    chk("t6.pending", 32'(bus.pending), 32'b111);
    drive(0, 3'b000, 1); step();
    drive(0, 3'b000, 0); step();
    chk("t6.fire", 32'(bus.evt_fire), 1);
    chk("t6.pend_fire", 32'(bus.pending), 32'b110);
    drive(1, 3'b000, 1); step();
    chk("t6.rst_fire", 32'(bus.evt_fire), 0);
    chk("t6.rst_pend", 32'(bus.pending), 0);
    chk("t6.rst_armed", 32'(bus.armed), 0);
    chk("t6.rst_onehot", 32'(bus.evt_onehot), 0);
    chk("t6.rst_id", 32'(bus.evt_id), 0);
`ifdef EVENT_WAIT_SCHED_COALESCE_CNT_EN
    chk("t6.rst_cnt", 32'(bus.coalesce_cnt), 0);
`endif
    drive(0, 3'b000, 0);
    fires = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.evt_fire) fires++;
    end
    drive(0, 3'b000, 1); step();
    chk("t6.armed", 32'(bus.armed), 1);
    drive(0, 3'b000, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.evt_fire) fires++;
    end
    chk("t6.no_fire", 32'(fires), 0);
    chk("t6.still_armed", 32'(bus.armed), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
